// File: rtl/valu_wb_buffer.sv
// -----------------------------------------------------------------------------
// valu_wb_buffer
//
// Writeback buffer between the fixed-latency vector ALU units and the VRF write
// port. The ALU side has no backpressure, so every result is captured in a FIFO
// and drained to the VRF over a valid/ready handshake. A credit counter
// (reserved slots) gates the issue stage so an in-flight result always has a
// free slot when it arrives.
//
// Optional feature macro: VALU_WB_BYPASS_EN
//   Defined     : an incoming result on an empty FIFO is presented on wb_*
//                 combinationally in the same cycle; taken without a write when
//                 wb_ready=1, otherwise written and held at the head.
//   Not defined : strict 1-cycle latency, no combinational in_* -> wb_* path.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   issue_valid  issue stage launches one ALU op (reserves one slot)
//   credit_ok    issue permitted this cycle (reserved < DEPTH)
//   in_vec       ALU result data
//   in_valid     ALU result valid
//   in_addr      ALU result destination address
//   wb_data      head entry data to VRF (0 when empty)
//   wb_addr      head entry address to VRF (0 when empty)
//   wb_valid     head entry valid
//   wb_ready     VRF accepts head entry
//   occupancy    entries currently stored
//   err_overflow sticky: push to full FIFO, or issue with credit_ok low
// -----------------------------------------------------------------------------
module valu_wb_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  credit_ok,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [PTR_W:0]        occupancy,
    output logic                  err_overflow
);

    localparam int             ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     occ_q, occ_d;
    logic [PTR_W:0]     rsv_q, rsv_d;
    logic               err_q, err_d;

    logic               empty_s;
    logic               full_s;
    logic               pop_fifo_s;   // handshake that consumes a stored entry
    logic               hs_s;         // any wb handshake (stored or bypassed)
    logic               wr_en_s;
    logic               drop_s;
    logic               issue_ok_s;
    logic [ENTRY_W-1:0] head_s;

    assign empty_s    = (occ_q == '0);
    assign full_s     = (occ_q == DEPTH_C);
    assign head_s     = mem_q[rd_ptr_q];
    assign pop_fifo_s = !empty_s && wb_ready;
    assign credit_ok  = (rsv_q < DEPTH_C);
    assign issue_ok_s = issue_valid && credit_ok;
    assign occupancy  = occ_q;
    assign err_overflow = err_q;

`ifdef VALU_WB_BYPASS_EN
    logic byp_take_s;

    // A result arriving on an empty FIFO is consumed directly if the VRF is ready.
    assign byp_take_s = empty_s && in_valid && wb_ready;
    assign hs_s       = wb_valid && wb_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
    assign wr_en_s    = in_valid && !byp_take_s && (!full_s || pop_fifo_s);
    assign drop_s     = in_valid && !byp_take_s && !wr_en_s;

    // Head presentation: stored head, else the incoming result, else zeros.
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        wb_addr  = '0;
        if (!empty_s) begin
            wb_valid = 1'b1;
            wb_data  = head_s[DATA_WIDTH-1:0];
            wb_addr  = head_s[ENTRY_W-1:DATA_WIDTH];
        end else if (in_valid) begin
            wb_valid = 1'b1;
            wb_data  = in_vec;
            wb_addr  = in_addr;
        end else begin
            wb_valid = 1'b0;
        end
    end
`else
    assign hs_s    = pop_fifo_s;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
    assign wr_en_s = in_valid && (!full_s || pop_fifo_s);
    assign drop_s  = in_valid && !wr_en_s;

    // Head presentation straight from storage; zeros while empty.
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        wb_addr  = '0;
        if (!empty_s) begin
            wb_valid = 1'b1;
            wb_data  = head_s[DATA_WIDTH-1:0];
            wb_addr  = head_s[ENTRY_W-1:DATA_WIDTH];
        end else begin
            wb_valid = 1'b0;
        end
    end
`endif

    // Next-state for pointers, occupancy, credits and the sticky error.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        rsv_d    = rsv_q;
        err_d    = err_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_fifo_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_fifo_s})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase

        case ({issue_ok_s, hs_s})
            2'b10:   rsv_d = rsv_q + (PTR_W + 1)'(1);
            2'b01:   rsv_d = rsv_q - (PTR_W + 1)'(1);
            default: rsv_d = rsv_q;
        endcase

        if (drop_s || (issue_valid && !credit_ok)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control state: async reset discards all stored and reserved entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rsv_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rsv_q    <= rsv_d;
            err_q    <= err_d;
        end
    end

    // Entry storage; contents are only observed when occupancy marks them live.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {in_addr, in_vec};
        end
    end

endmodule

// File: tb/tb_valu_wb_buffer.sv
module tb_valu_wb_buffer;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          credit_ok;
    logic [DW-1:0] in_vec;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_addr;
    logic          wb_valid;
    logic          wb_ready;
    logic [PW:0]   occupancy;
    logic          err_overflow;

    int checks = 0;
    int fails  = 0;

    valu_wb_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .credit_ok(credit_ok),
        .in_vec(in_vec), .in_valid(in_valid), .in_addr(in_addr),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .occupancy(occupancy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dat(input int a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_q[$];
        int pushed;
        int delivered;
        int cyc;

        rst = 1'b1; issue_valid = 1'b0; in_valid = 1'b0;
        in_vec = '0; in_addr = '0; wb_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset / idle state
        check("rst_credit", credit_ok, 1'b1);
        check("rst_valid", wb_valid, 1'b0);
        check("rst_occ", occupancy, 4'd0);
        check("rst_err", err_overflow, 1'b0);
        check("rst_data", wb_data, 64'd0);
        check("rst_addr", wb_addr, 32'd0);

        // Single op with wb_ready=1
        wb_ready = 1'b1;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1; in_vec = 64'hA5A5; in_addr = 32'h10;
        check("single_lat0", wb_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        check("single_valid", wb_valid, 1'b1);
        check("single_data", wb_data, 64'hA5A5);
        check("single_addr", wb_addr, 32'h10);
        check("single_occ", occupancy, 4'd1);
        tick();
        check("single_drained", wb_valid, 1'b0);
        check("single_occ0", occupancy, 4'd0);
        check("single_data0", wb_data, 64'd0);

        // Backpressure: 8 credits, then a 9th issue overflows
        wb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1;
            check("bp_credit_avail", credit_ok, 1'b1);
            tick();
        end
        issue_valid = 1'b0;
        check("bp_credit_full", credit_ok, 1'b0);
        check("bp_err_clean", err_overflow, 1'b0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        check("bp_err_set", err_overflow, 1'b1);
        check("bp_credit_still0", credit_ok, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_addr = 32'(i); in_vec = dat(i);
            tick();
        end
        in_valid = 1'b0;
        check("bp_occ8", occupancy, 4'd8);
        check("bp_head", wb_addr, 32'd0);
        tick();
        check("bp_hold_addr", wb_addr, 32'd0);
        check("bp_hold_data", wb_data, dat(0));
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_drain_valid", wb_valid, 1'b1);
            check("bp_drain_addr", wb_addr, 32'(i));
            check("bp_drain_data", wb_data, dat(i));
            tick();
        end
        wb_ready = 1'b0;
        check("bp_empty", wb_valid, 1'b0);
        check("bp_occ0", occupancy, 4'd0);
        check("bp_credit_back", credit_ok, 1'b1);
        check("bp_err_sticky", err_overflow, 1'b1);
        do_reset();
        check("rst_clears_err", err_overflow, 1'b0);

        // Full FIFO: simultaneous push+pop, then push-when-full drop
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1; in_valid = 1'b1;
            in_addr = 32'(16 + i); in_vec = dat(16 + i);
            tick();
        end
        issue_valid = 1'b0; in_valid = 1'b0;
        check("full_occ8", occupancy, 4'd8);
        wb_ready = 1'b1; in_valid = 1'b1; in_addr = 32'd24; in_vec = dat(24);
        check("full_pp_head", wb_addr, 32'd16);
        tick();
        wb_ready = 1'b0; in_valid = 1'b0;
        check("full_pp_occ", occupancy, 4'd8);
        check("full_pp_err", err_overflow, 1'b0);
        check("full_pp_newhead", wb_addr, 32'd17);
        in_valid = 1'b1; in_addr = 32'd99; in_vec = dat(99);
        tick();
        in_valid = 1'b0;
        check("full_drop_err", err_overflow, 1'b1);
        check("full_drop_occ", occupancy, 4'd8);
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("full_drain_addr", wb_addr, 32'(17 + i));
            check("full_drain_data", wb_data, dat(17 + i));
            tick();
        end
        wb_ready = 1'b0;
        check("full_drain_empty", wb_valid, 1'b0);
        do_reset();

        // Pointer wrap: 20 results, wb_ready toggling 1010...
        pushed = 0; delivered = 0; cyc = 0;
        while (delivered < 20 && cyc < 200) begin
            wb_ready = (cyc % 2 == 0);
            if (pushed < 20 && (cyc % 3) != 2) begin
                in_valid = 1'b1; issue_valid = 1'b1;
                in_addr = 32'(100 + pushed); in_vec = dat(100 + pushed);
            end else begin
                in_valid = 1'b0; issue_valid = 1'b0;
            end
            check("wrap_valid", wb_valid, exp_q.size() != 0);
            check("wrap_occ", occupancy, 4'(exp_q.size()));
            checks++;
            assert (occupancy <= 4'd8) else begin
                fails++;
                $error("FAIL wrap_occ_bound: observed %0d expected <= 8", occupancy);
            end
            if (exp_q.size() != 0 && wb_ready) begin
                check("wrap_addr", wb_addr, 32'(exp_q[0]));
                check("wrap_data", wb_data, dat(exp_q[0]));
                void'(exp_q.pop_front());
                delivered++;
            end
            if (in_valid) begin
                exp_q.push_back(100 + pushed);
                pushed++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0;
        check("wrap_delivered", delivered, 20);
        check("wrap_occ_end", occupancy, 4'd0);
        check("wrap_err", err_overflow, 1'b0);
        check("wrap_credit", credit_ok, 1'b1);

        // Reset mid-stream with occupancy=5
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1; in_valid = 1'b1;
            in_addr = 32'(200 + i); in_vec = dat(200 + i);
            tick();
        end
        issue_valid = 1'b0; in_valid = 1'b0;
        check("mid_occ5", occupancy, 4'd5);
        check("mid_valid", wb_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_valid", wb_valid, 1'b0);
        check("mid_async_occ", occupancy, 4'd0);
        check("mid_async_data", wb_data, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_credit", credit_ok, 1'b1);
        check("mid_valid_after", wb_valid, 1'b0);
        check("mid_occ_after", occupancy, 4'd0);
        check("mid_err_after", err_overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
